// File: rtl/dbf_pkg.sv
// dbf_pkg: shared definitions for the DBF line sequencer slice.
// Holds the default bus widths and the line-sequencer FSM state enum.
package dbf_pkg;

  localparam int unsigned ADDR_WD_DEF = 8;   // delay-LUT address width
  localparam int unsigned CNT_WD_DEF  = 16;  // sample / zone-length counter width
  localparam int unsigned ZONE_WD_DEF = 6;   // zone index / zone count width

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StTx,
    StSettle,
    StRx,
    StDone
  } seq_state_e;

endpackage

// File: rtl/dbf_zone_ctr.sv
// dbf_zone_ctr: receive-window counters for dbf_line_seq.
// Holds sample_cnt, zone_cnt and zone_idx. All counters sit at zero while run is low,
// so each receive window starts from a clean state.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   run             high for every receive (start) cycle
//   zone_len_m1     samples per zone minus one (already clamped to >= 0)
//   num_zones_m1    focal zones minus one (already clamped to >= 0)
//   rx_len_m1       receive samples minus one
//   zone_idx        current focal zone index
//   zone_step       this cycle closes a zone and another zone follows
//   rx_last         this cycle is the last receive sample
module dbf_zone_ctr
  import dbf_pkg::*;
#(
  parameter int unsigned CNT_WD  = CNT_WD_DEF,
  parameter int unsigned ZONE_WD = ZONE_WD_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic [CNT_WD-1:0]  zone_len_m1,
  input  logic [ZONE_WD-1:0] num_zones_m1,
  input  logic [CNT_WD-1:0]  rx_len_m1,
  output logic [ZONE_WD-1:0] zone_idx,
  output logic               zone_step,
  output logic               rx_last
);

  logic [CNT_WD-1:0] sample_cnt;
  logic [CNT_WD-1:0] zone_cnt;
  logic              zone_wrap;

  assign zone_wrap = (zone_cnt == zone_len_m1);
  assign rx_last   = run && (sample_cnt == rx_len_m1);
  // No step on the final sample: a new zone would start after the window closes.
  assign zone_step = run && zone_wrap && (zone_idx < num_zones_m1) && !rx_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt <= '0;
      zone_cnt   <= '0;
      zone_idx   <= '0;
    end else if (!run) begin
      sample_cnt <= '0;
      zone_cnt   <= '0;
      zone_idx   <= '0;
    end else begin
      sample_cnt <= sample_cnt + CNT_WD'(1);
      zone_cnt   <= zone_wrap ? '0 : zone_cnt + CNT_WD'(1);
      if (zone_step) begin
        zone_idx <= zone_idx + ZONE_WD'(1);
      end
    end
  end

endmodule

// File: rtl/dbf_line_seq.sv
// dbf_line_seq: per-scan-line controller for the DBF channel array.
// Waits out the transmit burst, preloads the zone-0 delay-LUT address, opens the receive
// window (start) and steps the shared LUT address once per focal zone.
// Optional macro DBF_SEQ_ABORT_EN adds the abort input and line_abort output.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   abort              (DBF_SEQ_ABORT_EN) cancel the current line
//   line_abort         (DBF_SEQ_ABORT_EN) one-cycle pulse when a line is aborted
//   line_trig          one-cycle new-line request
//   tx_en              transmit active
//   cfg_line_base      LUT base address for the line
//   cfg_num_zones      focal zones per line (0 treated as 1)
//   cfg_zone_len       samples per zone (0 treated as 1)
//   cfg_rx_len         receive samples per line (0 = no receive window)
//   start              receive window enable to all channels
//   dbf_lut_addr       delay-LUT address to all channels
//   dbf_lut_we         one-cycle LUT update strobe
//   busy               not idle
//   line_done          one-cycle end-of-line pulse
//   tx_timeout_err     sticky, tx_en never rose after a trigger
//   trig_overrun       sticky, line_trig seen while busy
module dbf_line_seq
  import dbf_pkg::*;
#(
  parameter int unsigned ADDR_WD    = ADDR_WD_DEF,
  parameter int unsigned CNT_WD     = CNT_WD_DEF,
  parameter int unsigned ZONE_WD    = ZONE_WD_DEF,
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned TX_TIMEOUT = 4096
) (
  input  logic               clk,
  input  logic               rst_n,
`ifdef DBF_SEQ_ABORT_EN
  input  logic               abort,
  output logic               line_abort,
`endif
  input  logic               line_trig,
  input  logic               tx_en,
  input  logic [ADDR_WD-1:0] cfg_line_base,
  input  logic [ZONE_WD-1:0] cfg_num_zones,
  input  logic [CNT_WD-1:0]  cfg_zone_len,
  input  logic [CNT_WD-1:0]  cfg_rx_len,
  output logic               start,
  output logic [ADDR_WD-1:0] dbf_lut_addr,
  output logic               dbf_lut_we,
  output logic               busy,
  output logic               line_done,
  output logic               tx_timeout_err,
  output logic               trig_overrun
);

  localparam int unsigned SET_WD = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int unsigned TMO_WD = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT) : 1;

  seq_state_e state;

  // Shadow copy of the line configuration, captured on the accepted trigger.
  logic [ADDR_WD-1:0] sh_base;
  logic [ZONE_WD-1:0] sh_nz_m1;
  logic [CNT_WD-1:0]  sh_zl_m1;
  logic [CNT_WD-1:0]  sh_rx_m1;
  logic               sh_rx_zero;

  logic [SET_WD-1:0]  settle_cnt;
  logic [TMO_WD-1:0]  tmo_cnt;

  logic [ZONE_WD-1:0] zone_idx;
  logic               zone_step;
  logic               rx_last;
  logic               abort_hit;

`ifdef DBF_SEQ_ABORT_EN
  assign abort_hit = abort && (state != StIdle);
`else
  assign abort_hit = 1'b0;
`endif

  assign busy = (state != StIdle);

  dbf_zone_ctr #(
    .CNT_WD  (CNT_WD),
    .ZONE_WD (ZONE_WD)
  ) u_zone_ctr (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (state == StRx),
    .zone_len_m1  (sh_zl_m1),
    .num_zones_m1 (sh_nz_m1),
    .rx_len_m1    (sh_rx_m1),
    .zone_idx     (zone_idx),
    .zone_step    (zone_step),
    .rx_last      (rx_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= StIdle;
      sh_base        <= '0;
      sh_nz_m1       <= '0;
      sh_zl_m1       <= '0;
      sh_rx_m1       <= '0;
      sh_rx_zero     <= 1'b0;
      settle_cnt     <= '0;
      tmo_cnt        <= '0;
      start          <= 1'b0;
      dbf_lut_addr   <= '0;
      dbf_lut_we     <= 1'b0;
      line_done      <= 1'b0;
      tx_timeout_err <= 1'b0;
      trig_overrun   <= 1'b0;
`ifdef DBF_SEQ_ABORT_EN
      line_abort     <= 1'b0;
`endif
    end else begin
      // Strobes default low; each is raised for exactly one cycle below.
      dbf_lut_we <= 1'b0;
      line_done  <= 1'b0;
`ifdef DBF_SEQ_ABORT_EN
      line_abort <= 1'b0;
`endif
      if (line_trig && (state != StIdle)) begin
        trig_overrun <= 1'b1;
      end

      if (abort_hit) begin
        state <= StIdle;
        start <= 1'b0;
`ifdef DBF_SEQ_ABORT_EN
        line_abort <= 1'b1;
`endif
      end else begin
        unique case (state)
          StIdle: begin
            if (line_trig) begin
              sh_base        <= cfg_line_base;
              sh_nz_m1       <= (cfg_num_zones == '0) ? '0 : cfg_num_zones - ZONE_WD'(1);
              sh_zl_m1       <= (cfg_zone_len == '0) ? '0 : cfg_zone_len - CNT_WD'(1);
              sh_rx_m1       <= cfg_rx_len - CNT_WD'(1);
              sh_rx_zero     <= (cfg_rx_len == '0);
              tx_timeout_err <= 1'b0;
              tmo_cnt        <= '0;
              state          <= StArm;
            end
          end
          StArm: begin
            if (tx_en) begin
              state <= StTx;
            end else if (tmo_cnt == TMO_WD'(TX_TIMEOUT - 1)) begin
              tx_timeout_err <= 1'b1;
              state          <= StIdle;
            end else begin
              tmo_cnt <= tmo_cnt + TMO_WD'(1);
            end
          end
          StTx: begin
            if (!tx_en) begin
              // Zone-0 preload lands in the first settle cycle.
              dbf_lut_addr <= sh_base;
              dbf_lut_we   <= 1'b1;
              settle_cnt   <= '0;
              state        <= StSettle;
            end
          end
          StSettle: begin
            if (settle_cnt == SET_WD'(SETTLE_CYC - 1)) begin
              if (sh_rx_zero) begin
                line_done <= 1'b1;
                state     <= StDone;
              end else begin
                start <= 1'b1;
                state <= StRx;
              end
            end else begin
              settle_cnt <= settle_cnt + SET_WD'(1);
            end
          end
          StRx: begin
            if (rx_last) begin
              start     <= 1'b0;
              line_done <= 1'b1;
              state     <= StDone;
            end else if (zone_step) begin
              // zone_idx increments on this same edge, so address the next zone.
              dbf_lut_addr <= sh_base + ADDR_WD'(zone_idx) + ADDR_WD'(1);
              dbf_lut_we   <= 1'b1;
            end
          end
          StDone: begin
            state <= StIdle;
          end
          default: begin
            state <= StIdle;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dbf_line_seq.sv
// tb_dbf_line_seq: directed self-checking bench for dbf_line_seq (default parameters).
// Abort scenario is compiled in only when DBF_SEQ_ABORT_EN is defined.
module tb_dbf_line_seq;

  logic        clk;
  logic        rst_n;
  logic        line_trig;
  logic        tx_en;
  logic [7:0]  cfg_line_base;
  logic [5:0]  cfg_num_zones;
  logic [15:0] cfg_zone_len;
  logic [15:0] cfg_rx_len;
  logic        start;
  logic [7:0]  dbf_lut_addr;
  logic        dbf_lut_we;
  logic        busy;
  logic        line_done;
  logic        tx_timeout_err;
  logic        trig_overrun;
`ifdef DBF_SEQ_ABORT_EN
  logic        abort;
  logic        line_abort;
`endif

  int n_checks = 0;
  int n_errors = 0;

  dbf_line_seq u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
`ifdef DBF_SEQ_ABORT_EN
    .abort          (abort),
    .line_abort     (line_abort),
`endif
    .line_trig      (line_trig),
    .tx_en          (tx_en),
    .cfg_line_base  (cfg_line_base),
    .cfg_num_zones  (cfg_num_zones),
    .cfg_zone_len   (cfg_zone_len),
    .cfg_rx_len     (cfg_rx_len),
    .start          (start),
    .dbf_lut_addr   (dbf_lut_addr),
    .dbf_lut_we     (dbf_lut_we),
    .busy           (busy),
    .line_done      (line_done),
    .tx_timeout_err (tx_timeout_err),
    .trig_overrun   (trig_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Trigger a line, then scramble cfg (must be ignored), hold tx_en for tx_cyc cycles and
  // drop it. Returns in the first SETTLE cycle.
  task automatic launch(input logic [7:0] base, input logic [5:0] nz, input logic [15:0] zl,
                        input logic [15:0] rx, input int tx_cyc);
    cfg_line_base = base;
    cfg_num_zones = nz;
    cfg_zone_len  = zl;
    cfg_rx_len    = rx;
    line_trig     = 1'b1;
    tick();
    line_trig     = 1'b0;
    cfg_line_base = 8'hA5;
    cfg_num_zones = 6'd9;
    cfg_zone_len  = 16'd1;
    cfg_rx_len    = 16'd1;
    tx_en         = 1'b1;
    repeat (tx_cyc) tick();
    tx_en = 1'b0;
    tick();
  endtask

  // Recorded activity from run_until_idle (stimulus only, no comparisons).
  logic [7:0] strobe_q[$];
  int         n_start;
  int         n_done;
  int         done_at;
  int         b2b;
  logic       hung;

  task automatic run_until_idle(input int bound);
    logic prev_we = 1'b0;
    strobe_q.delete();
    n_start = 0;
    n_done  = 0;
    done_at = -1;
    b2b     = 0;
    hung    = 1'b1;
    for (int i = 0; i < bound; i++) begin
      if (dbf_lut_we) begin
        strobe_q.push_back(dbf_lut_addr);
        if (prev_we) b2b++;
      end
      prev_we = dbf_lut_we;
      if (start) n_start++;
      if (line_done) begin
        n_done++;
        done_at = i;
      end
      if (!busy) begin
        hung = 1'b0;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    n_checks++; if (start !== 1'b0) begin n_errors++; $display("FAIL reset_start: got %b want 0", start); end
    n_checks++; if (dbf_lut_we !== 1'b0) begin n_errors++; $display("FAIL reset_we: got %b want 0", dbf_lut_we); end
    n_checks++; if (dbf_lut_addr !== 8'h00) begin n_errors++; $display("FAIL reset_addr: got %h want 00", dbf_lut_addr); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (line_done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b want 0", line_done); end
    n_checks++; if (tx_timeout_err !== 1'b0) begin n_errors++; $display("FAIL reset_tmo: got %b want 0", tx_timeout_err); end
    n_checks++; if (trig_overrun !== 1'b0) begin n_errors++; $display("FAIL reset_ovr: got %b want 0", trig_overrun); end
    rst_n = 1'b1;
    repeat (2) tick();
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL idle_after_reset: busy got %b want 0", busy); end
  endtask

  task automatic test_basic_line();
    logic [7:0] exp_addr;
    logic       exp_we;
    launch(8'h10, 6'd4, 16'd8, 16'd40, 20);
    n_checks++; if (dbf_lut_we !== 1'b1) begin n_errors++; $display("FAIL basic_preload_we: got %b want 1", dbf_lut_we); end
    n_checks++; if (dbf_lut_addr !== 8'h10) begin n_errors++; $display("FAIL basic_preload_addr: got %h want 10", dbf_lut_addr); end
    n_checks++; if (start !== 1'b0) begin n_errors++; $display("FAIL basic_settle_start: got %b want 0", start); end
    n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL basic_busy: got %b want 1", busy); end
    // start must rise exactly 5 cycles after the first tx_en=0 cycle in TX
    for (int i = 2; i <= 5; i++) begin
      tick();
      n_checks++;
      if (start !== (i == 5)) begin
        n_errors++; $display("FAIL basic_start_latency t0+%0d: got %b want %b", i, start, (i == 5));
      end
      n_checks++; if (dbf_lut_we !== 1'b0) begin n_errors++; $display("FAIL basic_settle_we t0+%0d: got %b want 0", i, dbf_lut_we); end
    end
    exp_addr = 8'h10;
    for (int c = 0; c < 40; c++) begin
      exp_we = (c == 8) || (c == 16) || (c == 24);
      if (exp_we) exp_addr = 8'h10 + 8'(c / 8);
      n_checks++; if (start !== 1'b1) begin n_errors++; $display("FAIL basic_rx_start c%0d: got %b want 1", c, start); end
      n_checks++; if (dbf_lut_we !== exp_we) begin n_errors++; $display("FAIL basic_rx_we c%0d: got %b want %b", c, dbf_lut_we, exp_we); end
      n_checks++; if (dbf_lut_addr !== exp_addr) begin n_errors++; $display("FAIL basic_rx_addr c%0d: got %h want %h", c, dbf_lut_addr, exp_addr); end
      n_checks++; if (line_done !== 1'b0) begin n_errors++; $display("FAIL basic_rx_done c%0d: got %b want 0", c, line_done); end
      tick();
    end
    n_checks++; if (start !== 1'b0) begin n_errors++; $display("FAIL basic_start_fall: got %b want 0", start); end
    n_checks++; if (line_done !== 1'b1) begin n_errors++; $display("FAIL basic_line_done: got %b want 1", line_done); end
    tick();
    n_checks++; if (line_done !== 1'b0) begin n_errors++; $display("FAIL basic_done_pulse: got %b want 0", line_done); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL basic_idle: busy got %b want 0", busy); end
  endtask

  task automatic test_addr_wrap();
    launch(8'hFE, 6'd3, 16'd2, 16'd6, 4);
    run_until_idle(40);
    n_checks++; if (hung !== 1'b0) begin n_errors++; $display("FAIL wrap_timeout: line did not finish in bound"); end
    n_checks++; if (strobe_q.size() !== 3) begin n_errors++; $display("FAIL wrap_count: got %0d strobes want 3", strobe_q.size()); end
    if (strobe_q.size() == 3) begin
      n_checks++; if (strobe_q[0] !== 8'hFE) begin n_errors++; $display("FAIL wrap_addr0: got %h want fe", strobe_q[0]); end
      n_checks++; if (strobe_q[1] !== 8'hFF) begin n_errors++; $display("FAIL wrap_addr1: got %h want ff", strobe_q[1]); end
      n_checks++; if (strobe_q[2] !== 8'h00) begin n_errors++; $display("FAIL wrap_addr2: got %h want 00", strobe_q[2]); end
    end
    n_checks++; if (n_start !== 6) begin n_errors++; $display("FAIL wrap_start_len: got %0d want 6", n_start); end
    n_checks++; if (done_at !== 10) begin n_errors++; $display("FAIL wrap_done_at: got %0d want 10", done_at); end
    n_checks++; if (b2b !== 0) begin n_errors++; $display("FAIL wrap_we_b2b: got %0d want 0", b2b); end
  endtask

  task automatic test_zero_cfg();
    launch(8'h40, 6'd0, 16'd0, 16'd3, 2);
    run_until_idle(30);
    n_checks++; if (hung !== 1'b0) begin n_errors++; $display("FAIL zero_timeout: line did not finish in bound"); end
    n_checks++; if (strobe_q.size() !== 1) begin n_errors++; $display("FAIL zero_count: got %0d strobes want 1", strobe_q.size()); end
    if (strobe_q.size() >= 1) begin
      n_checks++; if (strobe_q[0] !== 8'h40) begin n_errors++; $display("FAIL zero_addr: got %h want 40", strobe_q[0]); end
    end
    n_checks++; if (n_start !== 3) begin n_errors++; $display("FAIL zero_start_len: got %0d want 3", n_start); end
    n_checks++; if (done_at !== 7) begin n_errors++; $display("FAIL zero_done_at: got %0d want 7", done_at); end
  endtask

  task automatic test_rx_zero();
    launch(8'h55, 6'd2, 16'd4, 16'd0, 3);
    run_until_idle(30);
    n_checks++; if (hung !== 1'b0) begin n_errors++; $display("FAIL rx0_timeout: line did not finish in bound"); end
    n_checks++; if (n_start !== 0) begin n_errors++; $display("FAIL rx0_start: got %0d start cycles want 0", n_start); end
    n_checks++; if (n_done !== 1) begin n_errors++; $display("FAIL rx0_done_cnt: got %0d want 1", n_done); end
    n_checks++; if (done_at !== 4) begin n_errors++; $display("FAIL rx0_done_at: got %0d want 4", done_at); end
    n_checks++; if (strobe_q.size() !== 1) begin n_errors++; $display("FAIL rx0_strobes: got %0d want 1", strobe_q.size()); end
  endtask

  task automatic test_overrun_glitch();
    int  starts;
    logic seen_done;
    launch(8'h20, 6'd2, 16'd4, 16'd10, 3);
    tick();
    tx_en = 1'b1;                      // glitch during SETTLE
    tick();
    tx_en = 1'b0;
    tick();
    tick();
    n_checks++; if (start !== 1'b1) begin n_errors++; $display("FAIL ovr_start_rise: got %b want 1", start); end
    n_checks++; if (trig_overrun !== 1'b0) begin n_errors++; $display("FAIL ovr_pre: got %b want 0", trig_overrun); end
    repeat (3) tick();
    line_trig     = 1'b1;              // second trigger during RX, plus tx_en glitch
    tx_en         = 1'b1;
    cfg_line_base = 8'h80;
    tick();
    line_trig = 1'b0;
    tx_en     = 1'b0;
    n_checks++; if (trig_overrun !== 1'b1) begin n_errors++; $display("FAIL ovr_set: got %b want 1", trig_overrun); end
    n_checks++; if (dbf_lut_we !== 1'b1) begin n_errors++; $display("FAIL ovr_step_we: got %b want 1", dbf_lut_we); end
    n_checks++; if (dbf_lut_addr !== 8'h21) begin n_errors++; $display("FAIL ovr_step_addr: got %h want 21", dbf_lut_addr); end
    starts    = 0;
    seen_done = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (line_done) begin
        seen_done = 1'b1;
        break;
      end
      if (start) starts++;
      tick();
    end
    n_checks++; if (seen_done !== 1'b1) begin n_errors++; $display("FAIL ovr_done_seen: got %b want 1", seen_done); end
    n_checks++; if (starts !== 6) begin n_errors++; $display("FAIL ovr_rest_len: got %0d want 6", starts); end
    line_trig = 1'b1;                  // same cycle as line_done: must not be accepted
    tick();
    line_trig = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL ovr_b2b_busy: got %b want 0", busy); end
    tick();
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL ovr_b2b_idle: got %b want 0", busy); end
    n_checks++; if (trig_overrun !== 1'b1) begin n_errors++; $display("FAIL ovr_sticky: got %b want 1", trig_overrun); end
  endtask

  task automatic test_tx_timeout();
    int seen;
    cfg_line_base = 8'h00;
    cfg_num_zones = 6'd1;
    cfg_zone_len  = 16'd1;
    cfg_rx_len    = 16'd2;
    line_trig     = 1'b1;
    tick();
    line_trig = 1'b0;
    seen      = 0;
    for (int i = 0; i < 4095; i++) begin
      if (start || line_done) seen++;
      tick();
    end
    n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL tmo_early_busy: got %b want 1", busy); end
    n_checks++; if (tx_timeout_err !== 1'b0) begin n_errors++; $display("FAIL tmo_early_err: got %b want 0", tx_timeout_err); end
    tick();
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL tmo_busy: got %b want 0", busy); end
    n_checks++; if (tx_timeout_err !== 1'b1) begin n_errors++; $display("FAIL tmo_err: got %b want 1", tx_timeout_err); end
    n_checks++; if (line_done !== 1'b0) begin n_errors++; $display("FAIL tmo_no_done: got %b want 0", line_done); end
    n_checks++; if (seen !== 0) begin n_errors++; $display("FAIL tmo_activity: got %0d start/done cycles want 0", seen); end
    line_trig = 1'b1;
    tick();
    line_trig = 1'b0;
    n_checks++; if (tx_timeout_err !== 1'b0) begin n_errors++; $display("FAIL tmo_clear: got %b want 0", tx_timeout_err); end
    tx_en = 1'b1;
    tick();
    tx_en = 1'b0;
    tick();
    run_until_idle(20);
    n_checks++; if (hung !== 1'b0) begin n_errors++; $display("FAIL tmo_next_hung: line did not finish in bound"); end
    n_checks++; if (n_done !== 1) begin n_errors++; $display("FAIL tmo_next_done: got %0d want 1", n_done); end
  endtask

`ifdef DBF_SEQ_ABORT_EN
  task automatic test_abort();
    launch(8'h30, 6'd4, 16'd8, 16'd40, 2);
    repeat (4) tick();
    repeat (10) tick();
    n_checks++; if (start !== 1'b1) begin n_errors++; $display("FAIL abort_pre_start: got %b want 1", start); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++; if (start !== 1'b0) begin n_errors++; $display("FAIL abort_start: got %b want 0", start); end
    n_checks++; if (line_abort !== 1'b1) begin n_errors++; $display("FAIL abort_pulse: got %b want 1", line_abort); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL abort_busy: got %b want 0", busy); end
    n_checks++; if (dbf_lut_we !== 1'b0) begin n_errors++; $display("FAIL abort_we: got %b want 0", dbf_lut_we); end
    n_checks++; if (line_done !== 1'b0) begin n_errors++; $display("FAIL abort_done: got %b want 0", line_done); end
    tick();
    n_checks++; if (line_abort !== 1'b0) begin n_errors++; $display("FAIL abort_pulse_end: got %b want 0", line_abort); end
    n_checks++; if (line_done !== 1'b0) begin n_errors++; $display("FAIL abort_done_late: got %b want 0", line_done); end
  endtask
`endif

  task automatic test_reset_mid_rx();
    launch(8'h60, 6'd2, 16'd2, 16'd20, 2);
    repeat (4) tick();
    repeat (3) tick();
    n_checks++; if (start !== 1'b1) begin n_errors++; $display("FAIL rst_mid_pre_start: got %b want 1", start); end
    n_checks++; if (dbf_lut_addr !== 8'h61) begin n_errors++; $display("FAIL rst_mid_pre_addr: got %h want 61", dbf_lut_addr); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (start !== 1'b0) begin n_errors++; $display("FAIL rst_mid_start: got %b want 0", start); end
    n_checks++; if (dbf_lut_addr !== 8'h00) begin n_errors++; $display("FAIL rst_mid_addr: got %h want 00", dbf_lut_addr); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    n_checks++; if (trig_overrun !== 1'b0) begin n_errors++; $display("FAIL rst_mid_ovr: got %b want 0", trig_overrun); end
    n_checks++; if (dbf_lut_we !== 1'b0) begin n_errors++; $display("FAIL rst_mid_we: got %b want 0", dbf_lut_we); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n         = 1'b0;
    line_trig     = 1'b0;
    tx_en         = 1'b0;
    cfg_line_base = '0;
    cfg_num_zones = '0;
    cfg_zone_len  = '0;
    cfg_rx_len    = '0;
`ifdef DBF_SEQ_ABORT_EN
    abort         = 1'b0;
`endif
    test_reset();
    test_basic_line();
    test_addr_wrap();
    test_zero_cfg();
    test_rx_zero();
    test_overrun_glitch();
    test_tx_timeout();
`ifdef DBF_SEQ_ABORT_EN
    test_abort();
`endif
    test_reset_mid_rx();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dbf_line_seq.md
Name: dbf_line_seq

Overview:
- Per-scan-line controller for the DBF channel array.
- Waits out the transmit burst, then drives the shared `start`, `dbf_lut_addr` and `dbf_lut_we` fanout that every channel's coarse/fine delay LUT consumes.
- Steps the LUT address once per focal zone during receive.
- Sits between the system line trigger / transmit controller and all dbf_chNN instances.

Parameters:
- ADDR_WD, 8, width of the delay-LUT address bus (matches channel LUT address width)
- CNT_WD, 16, width of sample and zone-length counters
- ZONE_WD, 6, width of the zone index / zone count
- SETTLE_CYC, 4, cycles between tx_en falling and start rising (LUT read latency)
- TX_TIMEOUT, 4096, max cycles waiting for tx_en to rise after a trigger

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- line_trig  in  1  one-cycle new-scan-line request
- tx_en  in  1  transmit active, from the TX controller
- cfg_line_base  in  ADDR_WD  LUT base address for this line
- cfg_num_zones  in  ZONE_WD  focal zones per line (0 treated as 1)
- cfg_zone_len  in  CNT_WD  samples per zone (0 treated as 1)
- cfg_rx_len  in  CNT_WD  receive samples per line (0 means no receive window)
- start  out  1  receive window enable to all channels
- dbf_lut_addr  out  ADDR_WD  delay-LUT address to all channels
- dbf_lut_we  out  1  one-cycle LUT update strobe, valid with dbf_lut_addr
- busy  out  1  high in any state other than IDLE
- line_done  out  1  one-cycle pulse at the end of a line
- tx_timeout_err  out  1  sticky; set on timeout, cleared by the next accepted line_trig
- trig_overrun  out  1  sticky; set by a line_trig while busy, cleared only by reset

Behaviour:
- Reset: all outputs 0; FSM in IDLE; all counters 0. Asynchronous assertion, synchronous release.
- Configuration is sampled only in IDLE on line_trig. It is held in shadow registers for the whole line; mid-line cfg changes are ignored.
- FSM states and transitions:
  - IDLE: line_trig=1 → latch cfg, clear tx_timeout_err, go to ARM. Otherwise stay.
  - ARM: tx_en=1 → TX. If TX_TIMEOUT cycles elapse with tx_en=0 → set tx_timeout_err, go to IDLE (no line_done).
  - TX: stay while tx_en=1; tx_en=0 → SETTLE.
  - SETTLE:
    - First cycle drives dbf_lut_addr=line_base and dbf_lut_we=1 (zone-0 preload).
    - After SETTLE_CYC cycles → RX, or → DONE if rx_len=0.
  - RX:
    - start=1 for exactly rx_len cycles.
    - sample_cnt runs 0..rx_len-1; zone_cnt counts 0..zone_len-1 and then wraps.
    - On a zone_cnt wrap with zone_idx < num_zones-1: zone_idx+1 on the next cycle, dbf_lut_addr=line_base+zone_idx (mod 2^ADDR_WD), dbf_lut_we=1 for one cycle.
    - The last zone persists until rx_len is reached.
    - At sample_cnt=rx_len-1 → DONE.
  - DONE: line_done=1 for one cycle, start=0 → IDLE.
- Latency figures:
  - start rises SETTLE_CYC+1 cycles after the first cycle with tx_en=0 in TX.
  - The k-th update strobe (k≥1) occurs on start-cycle k*zone_len, counting from 0.
- Output timing: dbf_lut_we is never high two consecutive cycles. dbf_lut_addr holds its last value between strobes.
- tx_en glitch: tx_en rising again in SETTLE/RX is ignored; it does not restart the line.
- Back-to-back: line_trig in the same cycle as line_done (DONE) counts as overrun. It is accepted only in IDLE.

Optional Feature:
- DBF_SEQ_ABORT_EN
- Defined:
  - Adds input `abort` (1 bit) and output `line_abort` (1 bit).
  - abort=1 in any non-IDLE state: next cycle FSM=IDLE, start=0, dbf_lut_we=0, line_abort pulses 1 cycle, no line_done.
  - abort takes priority over all transitions in the same cycle.
- Undefined: no abort/line_abort ports; lines always run to DONE or timeout.

Decomposition:
- Shared package (dbf_pkg):
  - FSM state enum (IDLE, ARM, TX, SETTLE, RX, DONE)
  - default widths ADDR_WD/CNT_WD/ZONE_WD
- One natural sub-module: dbf_zone_ctr. It holds sample_cnt, zone_cnt and zone_idx, and outputs zone_step and rx_last.

Test Plan:
- num_zones=4, zone_len=8, rx_len=40, line_base=0x10, tx_en high 20 cycles → we at SETTLE entry with addr 0x10; start high 40 cycles beginning 5 cycles after the first TX cycle with tx_en=0; we at start-cycles 8/16/24 with addr 0x11/0x12/0x13; no further strobes; line_done 1 cycle after start falls.
- line_base=0xFE, num_zones=3, zone_len=2, rx_len=6 → strobe addresses 0xFE, 0xFF, 0x00 (wrap).
- line_trig, tx_en held 0 for TX_TIMEOUT cycles → tx_timeout_err=1, busy=0, no start, no line_done; next line_trig clears tx_timeout_err.
- Second line_trig during RX → trig_overrun=1, current line completes unchanged; rx_len=0 → no start, line_done after SETTLE.
- num_zones=0, zone_len=0, rx_len=3 → treated as 1/1: only the preload strobe, start 3 cycles.
- With DBF_SEQ_ABORT_EN, assert abort at start-cycle 10 → start=0 next cycle, line_abort pulse, no line_done, busy=0; reset asserted mid-RX → all outputs 0 immediately.
